// File: rtl/score_pkg.sv
// Shared definitions for the score path: judgement grade codes and default widths.
package score_pkg;

   localparam logic [1:0] GRADE_MISS    = 2'b00;
   localparam logic [1:0] GRADE_EARLY   = 2'b01;
   localparam logic [1:0] GRADE_LATE    = 2'b10;
   localparam logic [1:0] GRADE_PERFECT = 2'b11;

   localparam int COMBO_W_DEFAULT = 8;
   localparam int N_LANES_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer,
// pointer moves just past the granted requester.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         grant_valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_next;
   int            idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      ptr_next    = ptr_reg;
      idx         = 0;
      if (en) begin
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_valid && req[idx]) begin
               grant[idx]  = 1'b1;
               grant_valid = 1'b1;
               ptr_next    = IW'((idx + 1) % N);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_reg <= '0;
      else       ptr_reg <= ptr_next;
   end

endmodule

// File: rtl/score_event_sequencer.sv
// Buffers one judgement per lane, serialises them round-robin onto the score counter
// and maintains the combo / max-combo counters that accompany each issued grade.
module score_event_sequencer
   import score_pkg::*;
#(
   parameter int N_LANES = N_LANES_DEFAULT,
   parameter int COMBO_W = COMBO_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 game_active,
   input  logic                 combo_clr,
   input  logic [N_LANES-1:0]   hit_valid,
   input  logic [2*N_LANES-1:0] hit_grade,
   output logic [1:0]           score_inp,
   output logic [COMBO_W-1:0]   score_combo,
   output logic [COMBO_W-1:0]   combo,
   output logic [COMBO_W-1:0]   max_combo,
   output logic                 busy,
   output logic                 drop_err
);

   localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

   logic [N_LANES-1:0] pend_valid_reg;
   logic [1:0]         pend_grade_reg [N_LANES];
   logic [N_LANES-1:0] grant;
   logic               grant_valid;
   logic [N_LANES-1:0] drop_lane;

   logic [COMBO_W-1:0] combo_reg, combo_next, combo_base;
   logic [COMBO_W-1:0] max_combo_reg, max_combo_next, max_base;
   logic [COMBO_W-1:0] score_combo_reg, score_combo_next;
   logic [1:0]         score_inp_reg, score_inp_next;
   logic [1:0]         sel_grade;
   logic               drop_err_reg, drop_err_next;

   rr_arbiter #(.N(N_LANES)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .en          (game_active),
      .req         (pend_valid_reg),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // A lane being granted this cycle frees its slot, so a same-cycle load is not a drop.
   genvar gi;
   generate
      for (gi = 0; gi < N_LANES; gi++) begin : g_slot
         assign drop_lane[gi] = game_active & hit_valid[gi] & pend_valid_reg[gi] & ~grant[gi];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               pend_valid_reg[gi] <= 1'b0;
               pend_grade_reg[gi] <= GRADE_MISS;
            end else if (!game_active) begin
               pend_valid_reg[gi] <= 1'b0;
            end else if (hit_valid[gi] && !drop_lane[gi]) begin
               pend_valid_reg[gi] <= 1'b1;
               pend_grade_reg[gi] <= hit_grade[2*gi +: 2];
            end else if (grant[gi]) begin
               pend_valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   // combo_clr zeroes the base first; a same-cycle grant then counts from zero.
   always_comb begin
      combo_base       = combo_clr ? '0 : combo_reg;
      max_base         = combo_clr ? '0 : max_combo_reg;
      sel_grade        = GRADE_MISS;
      combo_next       = combo_base;
      score_inp_next   = GRADE_MISS;
      score_combo_next = '0;
      for (int i = 0; i < N_LANES; i++)
         if (grant[i]) sel_grade = sel_grade | pend_grade_reg[i];
      if (grant_valid) begin
         if (sel_grade != GRADE_MISS) begin
            combo_next       = (combo_base == COMBO_MAX) ? combo_base : combo_base + 1'b1;
            score_inp_next   = sel_grade;
            score_combo_next = combo_next;
         end else begin
            combo_next = '0;
         end
      end
      max_combo_next = (combo_next > max_base) ? combo_next : max_base;
      drop_err_next  = (combo_clr ? 1'b0 : drop_err_reg) | (|drop_lane);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         combo_reg       <= '0;
         max_combo_reg   <= '0;
         score_inp_reg   <= GRADE_MISS;
         score_combo_reg <= '0;
         drop_err_reg    <= 1'b0;
      end else begin
         combo_reg       <= combo_next;
         max_combo_reg   <= max_combo_next;
         score_inp_reg   <= score_inp_next;
         score_combo_reg <= score_combo_next;
         drop_err_reg    <= drop_err_next;
      end
   end

   assign score_inp   = score_inp_reg;
   assign score_combo = score_combo_reg;
   assign combo       = combo_reg;
   assign max_combo   = max_combo_reg;
   assign busy        = |pend_valid_reg;
   assign drop_err    = drop_err_reg;

endmodule

// File: tb/tb_score_event_sequencer.sv
// Directed and random stimulus against a queue-of-slots reference model of the sequencer.
module tb_score_event_sequencer;
   import score_pkg::*;

   localparam int N = 4;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           game_active = 1'b0;
   logic           combo_clr = 1'b0;
   logic [N-1:0]   hit_valid = '0;
   logic [2*N-1:0] hit_grade = '0;
   logic [1:0]     score_inp;
   logic [CW-1:0]  score_combo, combo, max_combo;
   logic           busy, drop_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_pend [N];
   int m_grade [N];
   int m_ptr, m_combo, m_max, m_drop, m_inp, m_sc;

   score_event_sequencer #(.N_LANES(N), .COMBO_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .game_active (game_active),
      .combo_clr   (combo_clr),
      .hit_valid   (hit_valid),
      .hit_grade   (hit_grade),
      .score_inp   (score_inp),
      .score_combo (score_combo),
      .combo       (combo),
      .max_combo   (max_combo),
      .busy        (busy),
      .drop_err    (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int l = 0; l < N; l++) begin
         m_pend[l] = 0;
         m_grade[l] = 0;
      end
      m_ptr = 0; m_combo = 0; m_max = 0; m_drop = 0; m_inp = 0; m_sc = 0;
   endfunction

   function automatic void model_step(input logic [N-1:0] hv, input logic [2*N-1:0] hg,
                                      input logic ga, input logic clr);
      int g;
      g = -1;
      if (clr) begin
         m_combo = 0; m_max = 0; m_drop = 0;
      end
      m_inp = 0; m_sc = 0;
      if (!ga) begin
         for (int l = 0; l < N; l++) m_pend[l] = 0;
      end else begin
         for (int k = 0; k < N; k++)
            if (g < 0 && m_pend[(m_ptr + k) % N] != 0) g = (m_ptr + k) % N;
         if (g >= 0) begin
            m_pend[g] = 0;
            m_ptr = (g + 1) % N;
            if (m_grade[g] != 0) begin
               m_combo = (m_combo < CMAX) ? m_combo + 1 : CMAX;
               m_inp = m_grade[g];
               m_sc = m_combo;
            end else begin
               m_combo = 0;
            end
            if (m_combo > m_max) m_max = m_combo;
         end
         for (int l = 0; l < N; l++) begin
            if (hv[l]) begin
               if (m_pend[l] != 0) m_drop = 1;
               else begin
                  m_pend[l] = 1;
                  m_grade[l] = int'(hg[2*l +: 2]);
               end
            end
         end
      end
   endfunction

   task automatic check_all();
      int b;
      b = 0;
      for (int l = 0; l < N; l++) if (m_pend[l] != 0) b = 1;
      check("score_inp", int'(score_inp), m_inp);
      check("score_combo", int'(score_combo), m_sc);
      check("combo", int'(combo), m_combo);
      check("max_combo", int'(max_combo), m_max);
      check("busy", int'(busy), b);
      check("drop_err", int'(drop_err), m_drop);
   endtask

   task automatic step(input logic [N-1:0] hv, input logic [2*N-1:0] hg,
                       input logic ga, input logic clr);
      @(negedge clk);
      hit_valid = hv; hit_grade = hg; game_active = ga; combo_clr = clr;
      @(posedge clk);
      model_step(hv, hg, ga, clr);
      #1;
      check_all();
      if (m_inp != 0)
         $display("issue: grade=%0d score_combo=%0d combo=%0d max=%0d", m_inp, m_sc, m_combo, m_max);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_score_inp", int'(score_inp), 0);
      check("reset_combo", int'(combo), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_drop_err", int'(drop_err), 0);
      @(negedge clk);
      reset = 1'b0;

      // lane0 perfect x3, one every 4 clocks
      for (int i = 0; i < 3; i++) begin
         step(4'b0001, 8'b0000_0011, 1'b1, 1'b0);
         idle(3);
      end
      check("t1_combo3", int'(combo), 3);

      // all lanes in one cycle
      step(4'b1111, 8'b11_10_01_11, 1'b1, 1'b0);
      idle(5);

      // lane2 miss breaks combo, max kept
      step(4'b0100, 8'b00_00_00_00, 1'b1, 1'b0);
      idle(2);
      check("t3_combo_zero", int'(combo), 0);
      step(4'b0010, 8'b00_00_10_00, 1'b1, 1'b0);
      idle(2);

      // lane1 double hit while pending -> drop
      step(4'b0011, 8'b00_00_01_11, 1'b1, 1'b0);
      step(4'b0010, 8'b00_00_11_00, 1'b1, 1'b0);
      idle(4);
      check("t4_drop_sticky", int'(drop_err), 1);
      step('0, '0, 1'b1, 1'b1);
      check("t4_drop_cleared", int'(drop_err), 0);

      // saturation
      for (int i = 0; i < 260; i++) step(4'b0001, 8'b0000_0011, 1'b1, 1'b0);
      idle(2);
      check("t5_sat", int'(combo), CMAX);

      // async reset with pending lanes
      step(4'b0111, 8'b00_11_01_10, 1'b1, 1'b0);
      @(negedge clk);
      hit_valid = '0;
      #1 reset = 1'b1;
      #1;
      check("t6_rst_score_inp", int'(score_inp), 0);
      check("t6_rst_combo", int'(combo), 0);
      check("t6_rst_max", int'(max_combo), 0);
      check("t6_rst_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      idle(3);

      // game_active low flushes pending
      step(4'b1011, 8'b11_00_11_01, 1'b1, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0101, 8'b00_11_00_11, 1'b0, 1'b0);
      idle(2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0]   hv;
         logic [2*N-1:0] hg;
         logic           ga, clr;
         hv  = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
         hg  = (2*N)'($urandom);
         ga  = ($urandom_range(0, 19) != 0);
         clr = ($urandom_range(0, 39) == 0);
         step(hv, hg, ga, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
